// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute/relative jump, and a call/return address stack.
// Optional PC_STACK_TRAP_EN: a call on a full stack sends the PC to TRAP_VEC instead of the call target.
module pc_stack_unit #(
  parameter int              PC_W        = 8,
  parameter int              OFF_W       = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter logic [PC_W-1:0] TRAP_VEC    = '1
) (
  input  logic             CLK,
  input  logic             CLB,
  input  logic [PC_W-1:0]  A,
  input  logic [OFF_W-1:0] B,
  input  logic             SelPC,
  input  logic             IncPC,
  input  logic             LoadPC,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Hold,
  output logic [PC_W-1:0]  count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int DEP_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(STACK_DEPTH);

  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [DEP_W-1:0] depth, depth_nxt;
  logic [PC_W-1:0]  count_nxt, inc_val, target, b_ext;
  logic             err_nxt, push;
  logic [IDX_W-1:0] top_idx, push_idx;

  assign b_ext    = {{(PC_W-OFF_W){B[OFF_W-1]}}, B};
  assign inc_val  = count + PC_W'(1);
  // Relative offsets are taken from the current PC, not PC+1
  assign target   = SelPC ? (count + b_ext) : A;
  assign top_idx  = IDX_W'(depth - DEP_W'(1));
  assign push_idx = IDX_W'(depth);

  always_comb begin
    count_nxt = count;
    depth_nxt = depth;
    err_nxt   = stk_err;
    push      = 1'b0;
    if (!Hold) begin
      if (Ret) begin
        if (stk_empty) begin
          count_nxt = inc_val;
          err_nxt   = 1'b1;
        end else begin
          count_nxt = stack_mem[top_idx];
          depth_nxt = depth - DEP_W'(1);
        end
      end else if (Call) begin
        count_nxt = target;
        if (stk_full) begin
          err_nxt = 1'b1;
`ifdef PC_STACK_TRAP_EN
          count_nxt = TRAP_VEC;
`endif
        end else begin
          push      = 1'b1;
          depth_nxt = depth + DEP_W'(1);
        end
      end else if (LoadPC) begin
        count_nxt = target;
      end else if (IncPC) begin
        count_nxt = inc_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      count     <= RESET_VEC;
      depth     <= '0;
      stk_full  <= 1'b0;
      stk_empty <= 1'b1;
      stk_err   <= 1'b0;
    end else begin
      count     <= count_nxt;
      depth     <= depth_nxt;
      stk_full  <= (depth_nxt == DEPTH_MAX);
      stk_empty <= (depth_nxt == '0);
      stk_err   <= err_nxt;
    end
  end

  // Entry contents carry no reset; depth alone decides which entries are live
  always_ff @(posedge CLK) begin
    if (push) stack_mem[push_idx] <= inc_val;
  end

endmodule
